// File: rtl/data_mem_responder_pkg.sv
// Shared defines for the core's data-memory path: command encodings, default depth,
// MMIO addresses and small command-decode helpers.
package data_mem_responder_pkg;

  localparam int DM_DEPTH = 16384;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd9,
    MEM_SH   = 4'd10,
    MEM_SW   = 4'd11
  } mem_cmd_e;

  localparam logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF4;

  function automatic logic is_load(input logic [3:0] cmd);
    case (cmd)
      MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] cmd);
    case (cmd)
      MEM_SB, MEM_SH, MEM_SW: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Unknown command codes never fault.
  function automatic logic is_misaligned(input logic [3:0] cmd, input logic [1:0] off);
    case (cmd)
      MEM_LH, MEM_LHU, MEM_SH: return off[0];
      MEM_LW, MEM_SW:          return off != 2'b00;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage memory bus between the core (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic [31:0] mem_addr;
  logic [3:0]  mem_cmd;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  modport master (output mem_addr, output mem_cmd, output mem_din, input mem_dout);
  modport slave  (input mem_addr, input mem_cmd, input mem_din, output mem_dout);
endinterface

// File: rtl/data_mem_responder_load_fmt.sv
// dm_load_fmt: selects and extends the byte/half/word of a fetched word for a load.
// Returns zero for non-load commands and misaligned loads.
module dm_load_fmt
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [3:0]  cmd,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[8*off +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    data     = 32'h0;
    if (!is_misaligned(cmd, off)) begin
      case (cmd)
        MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
        MEM_LBU: data = {24'h0, byte_sel};
        MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
        MEM_LHU: data = {16'h0, half_sel};
        MEM_LW:  data = word;
        default: data = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array with byte-lane stores, combinational loads,
// sticky misalign capture and saturating load/store counters. Optional MMIO via DM_MMIO_EN.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH     = DM_DEPTH,
  parameter     INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic                 DM_misalign,
  output logic [31:0]          DM_err_addr,
  output logic [31:0]          DM_ld_cnt,
  output logic [31:0]          DM_st_cnt
`ifdef DM_MMIO_EN
  ,
  output logic [31:0]          DM_tohost,
  output logic                 DM_tohost_vld
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    cmd;
  logic          ld, st, mis, in_mmio;
  logic [3:0]    be;
  logic [31:0]   wdata, fmt_data;
  logic          misalign;
  logic [31:0]   err_addr, ld_cnt, st_cnt;
  logic          unused_addr;

  assign idx         = bus.mem_addr[AW+1:2];
  assign off         = bus.mem_addr[1:0];
  assign cmd         = bus.mem_cmd;
  assign ld          = is_load(cmd);
  assign st          = is_store(cmd);
  assign mis         = is_misaligned(cmd, off);
  assign unused_addr = ^bus.mem_addr[31:AW+2];

`ifdef DM_MMIO_EN
  logic [31:0] cycle_cnt, tohost;
  logic        tohost_vld, tohost_hit, cycle_hit;

  assign in_mmio    = bus.mem_addr[31:4] == 28'hFFF_FFFF;
  assign tohost_hit = (cmd == MEM_SW) && (bus.mem_addr == TOHOST_ADDR);
  assign cycle_hit  = (cmd == MEM_LW) && (bus.mem_addr == CYCLE_ADDR);
  assign DM_tohost     = tohost;
  assign DM_tohost_vld = tohost_vld;
`else
  assign in_mmio = 1'b0;
`endif

  always_comb begin
    be    = 4'b0000;
    wdata = bus.mem_din;
    if (rst && st && !mis && !in_mmio) begin
      case (cmd)
        MEM_SB: begin
          be        = 4'b0001 << off;
          wdata     = {4{bus.mem_din[7:0]}};
        end
        MEM_SH: begin
          be        = off[1] ? 4'b1100 : 4'b0011;
          wdata     = {2{bus.mem_din[15:0]}};
        end
        default: be = 4'b1111;
      endcase
    end
  end

  // The array has no reset: reset must never disturb committed data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  dm_load_fmt u_load_fmt (
    .word (mem[idx]),
    .off  (off),
    .cmd  (cmd),
    .data (fmt_data)
  );

  always_comb begin
    bus.mem_dout = 32'h0;
    if (rst) begin
`ifdef DM_MMIO_EN
      if (in_mmio) bus.mem_dout = cycle_hit ? cycle_cnt : 32'h0;
      else         bus.mem_dout = fmt_data;
`else
      bus.mem_dout = fmt_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      misalign <= 1'b0;
      err_addr <= 32'h0;
      ld_cnt   <= 32'h0;
      st_cnt   <= 32'h0;
    end else begin
      if (mis && !misalign) begin
        misalign <= 1'b1;
        err_addr <= bus.mem_addr;
      end
      if (ld && !mis && ld_cnt != 32'hFFFF_FFFF) ld_cnt <= ld_cnt + 32'd1;
      if (st && !mis && st_cnt != 32'hFFFF_FFFF) st_cnt <= st_cnt + 32'd1;
    end
  end

`ifdef DM_MMIO_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_cnt  <= 32'h0;
      tohost     <= 32'h0;
      tohost_vld <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (tohost_hit) begin
        tohost     <= bus.mem_din;
        tohost_vld <= 1'b1;
      end
    end
  end
`endif

  assign DM_misalign = misalign;
  assign DM_err_addr = err_addr;
  assign DM_ld_cnt   = ld_cnt;
  assign DM_st_cnt   = st_cnt;

endmodule
